// File: rtl/div_bcd_pkg.sv
// Shared types, constants and helpers for the divider-result BCD converter.
package div_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int unsigned BCD_W       = 4;
   localparam int unsigned ADD3_THRESH = 5;

   function automatic int unsigned bcd_width(input int unsigned digits);
      return BCD_W * digits;
   endfunction

   // 10^d, used to check that DIGITS can hold the largest N-bit value.
   function automatic longint unsigned pow10(input int unsigned d);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/div_result_bcd_if.sv
// Capture/result/handshake bundle between divider, converter and display stage.
interface div_result_bcd_if #(
   parameter int unsigned N      = 4,
   parameter int unsigned DIGITS = 2
);
   import div_bcd_pkg::*;

   logic                           start;
   logic [N-1:0]                   q_in;
   logic [N-1:0]                   r_in;
   logic                           div_zero;
   logic [bcd_width(DIGITS)-1:0]   q_bcd;
   logic [bcd_width(DIGITS)-1:0]   r_bcd;
   logic                           err;
   logic                           valid;
   logic                           ack;
   logic                           busy;

   modport master (
      output start, q_in, r_in, div_zero, ack,
      input  q_bcd, r_bcd, err, valid, busy
   );

   modport slave (
      input  start, q_in, r_in, div_zero, ack,
      output q_bcd, r_bcd, err, valid, busy
   );

endinterface

// File: rtl/div_result_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift left.
module dabble_step
   import div_bcd_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned DIGITS = 2
) (
   input  logic [bcd_width(DIGITS)+N-1:0] reg_in,
   output logic [bcd_width(DIGITS)+N-1:0] reg_out
);

   localparam int unsigned W = bcd_width(DIGITS) + N;

   logic [W-1:0] adj;

   // Per-digit unsigned add-3 correction followed by the 1-bit shift.
   always_comb begin
      adj = reg_in;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (adj[N + BCD_W*k +: BCD_W] >= 4'(ADD3_THRESH))
            adj[N + BCD_W*k +: BCD_W] = adj[N + BCD_W*k +: BCD_W] + 4'd3;
      end
      reg_out = adj << 1;
   end

endmodule

// File: rtl/div_result_bcd.sv
// Captures divider Q/R, converts both to packed BCD one bit per clock,
// and holds the result under a valid/ack handshake.
module div_result_bcd
   import div_bcd_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned DIGITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   div_result_bcd_if.slave  bus
);

   localparam int unsigned BW    = bcd_width(DIGITS);
   localparam int unsigned W     = BW + N;
   localparam int unsigned CNT_W = $clog2(N + 1);

   if (pow10(DIGITS) <= ((longint'(1) << N) - 1)) begin : g_digits_check
      $error("div_result_bcd: DIGITS too small to hold 2^N-1");
   end

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     shift_q, shift_r;
   logic [W-1:0]     next_q, next_r;
   logic             err_lat;
   logic [BW-1:0]    q_bcd_r, r_bcd_r;
   logic             err_r, valid_r;

   dabble_step #(.N(N), .DIGITS(DIGITS)) u_step_q (.reg_in(shift_q), .reg_out(next_q));
   dabble_step #(.N(N), .DIGITS(DIGITS)) u_step_r (.reg_in(shift_r), .reg_out(next_r));

   // Handshake FSM, lockstep shift registers and presented-result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         shift_q <= '0;
         shift_r <= '0;
         err_lat <= 1'b0;
         q_bcd_r <= '0;
         r_bcd_r <= '0;
         err_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shift_q <= {{BW{1'b0}}, bus.q_in};
                  shift_r <= {{BW{1'b0}}, bus.r_in};
                  err_lat <= bus.div_zero;
                  cnt     <= '0;
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               shift_q <= next_q;
               shift_r <= next_r;
               cnt     <= cnt + 1'b1;
               if (cnt == CNT_W'(N - 1)) begin
                  q_bcd_r <= next_q[W-1:N];
                  r_bcd_r <= next_r[W-1:N];
                  err_r   <= err_lat;
                  valid_r <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (bus.ack) begin
                  valid_r <= 1'b0;
                  if (bus.start) begin
                     shift_q <= {{BW{1'b0}}, bus.q_in};
                     shift_r <= {{BW{1'b0}}, bus.r_in};
                     err_lat <= bus.div_zero;
                     cnt     <= '0;
                     state   <= CONVERT;
                  end else begin
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.q_bcd = q_bcd_r;
   assign bus.r_bcd = r_bcd_r;
   assign bus.err   = err_r;
   assign bus.valid = valid_r;
   assign bus.busy  = (state == CONVERT);

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Downstream consumer of the combinational N-bit restoring divider.
- Captures quotient Q and remainder R on a start strobe and converts each to packed BCD with a sequential double-dabble (shift-and-add-3), one bit per clock.
- Holds the result under a valid/ack handshake for the display/7-segment stage that follows.
- Also carries a divide-by-zero flag alongside the result.

Parameters:
- N, 4, operand width; must match the divider's N.
- DIGITS, 2, BCD digits per converted value; must satisfy 10^DIGITS > 2^N-1, checked by an elaboration-time assertion.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to capture q_in/r_in/div_zero; sampled every cycle.
- q_in  in  N  quotient from divider.
- r_in  in  N  remainder from divider.
- div_zero  in  1  divisor was zero (B==0) for this result.
- q_bcd  out  4*DIGITS  packed BCD of quotient; digit 0 in [3:0].
- r_bcd  out  4*DIGITS  packed BCD of remainder.
- err  out  1  registered copy of div_zero for the presented result.
- valid  out  1  q_bcd/r_bcd/err hold a complete result.
- ack  in  1  consumer accepts result; meaningful only while valid=1.
- busy  out  1  conversion in progress.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, counter 0, shift registers 0; q_bcd=0, r_bcd=0, err=0, valid=0, busy=0. Takes priority over everything, including mid-conversion abort.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - start=1 loads shift_q={0(4*DIGITS), q_in} and shift_r likewise; latches div_zero; cnt=0; goes to CONVERT.
  - start=0 stays IDLE.
- CONVERT:
  - Each edge, for each register: every BCD digit >=5 gets +3 (combinational), then the whole register shifts left 1; cnt++.
  - Both registers step in lockstep.
  - After N steps (cnt==N-1 at the edge): copy BCD fields to q_bcd/r_bcd, err=latched flag, valid=1, go to DONE.
  - busy=1 throughout CONVERT only.
  - start is ignored in CONVERT; the inputs are not resampled.
- Latency: the capture edge is E0. valid rises after edge EN, so N clocks after capture (4 for N=4).
- DONE:
  - valid=1; outputs stable until ack is sampled high.
  - ack=1, start=0: go to IDLE, valid=0 next cycle, outputs keep their last value.
  - ack=1, start=1: reload immediately and go to CONVERT (back-to-back; valid=0 next cycle).
  - start=1 without ack is ignored.
- ack outside DONE has no effect.
- q_bcd/r_bcd/err change only on DONE entry or reset; intermediate shift values are never visible.
- Arithmetic:
  - Add-3 is applied per 4-bit digit and is unsigned. Digits never exceed 9 after N steps, given the parameter constraint.
  - The counter is $clog2(N+1) bits wide.
- div_zero does not alter the conversion. The divider's Q=all-ones and R=A are converted as given; err flags the result.

Decomposition:
- Package div_bcd_pkg:
  - state enum (IDLE, CONVERT, DONE).
  - constants BCD_W=4 and ADD3_THRESH=5.
  - function bcd_width(digits)=4*digits.
- Sub-module dabble_step (combinational): input [4*DIGITS+N-1:0] register, output adjusted-and-shifted register. Instantiated twice, once for Q and once for R.
- The top holds the FSM, counter, shift registers and output registers.

Test Plan:
- A=7,B=2 → q_in=3,r_in=1,div_zero=0, start 1 cycle → exactly 4 clocks later valid=1, q_bcd=8'h03, r_bcd=8'h01, err=0; busy=1 for those 4 cycles.
- q_in=15,r_in=10 → q_bcd=8'h15, r_bcd=8'h10; hold ack=0 for 10 cycles → valid and outputs stable; ack=1 → valid=0 next cycle.
- div_zero case A=9,B=0: q_in=15,r_in=9,div_zero=1 → q_bcd=8'h15, r_bcd=8'h09, err=1.
- start pulsed again at cycle 2 of a conversion with new q_in=1 → ignored; result reflects the first capture.
- In DONE, ack=1 and start=1 with q_in=12,r_in=0 → valid low next cycle, then 8'h12/8'h00 valid 4 clocks after that edge.
- rst=1 during cycle 2 of CONVERT → next cycle state IDLE, valid=0, busy=0, q_bcd=r_bcd=0, err=0; a fresh start then converts normally.
